// File: rtl/mult_rr_scheduler.sv
// Round-robin scheduler sharing one external fixed-latency signed multiplier among
// NUM_REQ requesters; products return in issue order through a credit-protected FIFO.
module mult_rr_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int IN_DATA_WIDTH  = 8,
  parameter int OUT_DATA_WIDTH = 16,
  parameter int MULT_LATENCY   = 1,
  parameter int FIFO_DEPTH     = 4,
  parameter int ID_W           = $clog2(NUM_REQ)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req_valid_i,
  output logic [NUM_REQ-1:0]                req_ready_o,
  input  logic [NUM_REQ*IN_DATA_WIDTH-1:0]  req_a_i,
  input  logic [NUM_REQ*IN_DATA_WIDTH-1:0]  req_b_i,
  output logic [IN_DATA_WIDTH-1:0]          mult_a_o,
  output logic [IN_DATA_WIDTH-1:0]          mult_b_o,
  output logic                              mult_vld_o,
  input  logic [OUT_DATA_WIDTH-1:0]         mult_p_i,
  output logic                              res_valid_o,
  input  logic                              res_ready_i,
  output logic [OUT_DATA_WIDTH-1:0]         res_data_o,
  output logic [ID_W-1:0]                   res_id_o,
  output logic                              idle_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SUM_W = CNT_W + 1;

  logic [ID_W-1:0]                                ptr_q, ptr_d;
  logic                                           mult_vld_q, mult_vld_d;
  logic [IN_DATA_WIDTH-1:0]                       mult_a_q, mult_a_d;
  logic [IN_DATA_WIDTH-1:0]                       mult_b_q, mult_b_d;
  logic [ID_W-1:0]                                issue_id_q, issue_id_d;
  logic [MULT_LATENCY-1:0]                        tag_vld_q, tag_vld_d;
  logic [MULT_LATENCY-1:0][ID_W-1:0]              tag_id_q, tag_id_d;
  logic [FIFO_DEPTH-1:0][OUT_DATA_WIDTH-1:0]      fifo_data_q, fifo_data_d;
  logic [FIFO_DEPTH-1:0][ID_W-1:0]                fifo_id_q, fifo_id_d;
  logic [PTR_W-1:0]                               wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]                               rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]                               count_q, count_d;

  logic                     grant_found;
  logic [ID_W-1:0]          grant_id;
  logic [ID_W-1:0]          cand;
  int                       idx;
  logic [IN_DATA_WIDTH-1:0] sel_a, sel_b;
  logic [SUM_W-1:0]         inflight;
  logic                     credit_ok;
  logic                     accept;
  logic                     push, pop;

  // First valid requester at or after the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    idx         = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = ID_W'(idx);
      if (!grant_found && req_valid_i[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == grant_id) begin
        sel_a = req_a_i[i*IN_DATA_WIDTH +: IN_DATA_WIDTH];
        sel_b = req_b_i[i*IN_DATA_WIDTH +: IN_DATA_WIDTH];
      end
    end
  end

  // Every issued operand pair owns a FIFO slot until popped, so pushes never overflow.
  always_comb begin
    inflight = SUM_W'(mult_vld_q);
    for (int k = 0; k < MULT_LATENCY; k++) begin
      inflight = inflight + SUM_W'(tag_vld_q[k]);
    end
    credit_ok = (SUM_W'(count_q) + inflight) < SUM_W'(FIFO_DEPTH);
    accept    = grant_found && credit_ok && !rst;
    req_ready_o = '0;
    if (accept) req_ready_o[grant_id] = 1'b1;
  end

  always_comb begin
    ptr_d      = ptr_q;
    mult_vld_d = accept;
    mult_a_d   = mult_a_q;
    mult_b_d   = mult_b_q;
    issue_id_d = issue_id_q;
    if (accept) begin
      ptr_d      = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
      mult_a_d   = sel_a;
      mult_b_d   = sel_b;
      issue_id_d = grant_id;
    end
    tag_vld_d    = tag_vld_q;
    tag_id_d     = tag_id_q;
    tag_vld_d[0] = mult_vld_q;
    tag_id_d[0]  = issue_id_q;
    for (int k = 1; k < MULT_LATENCY; k++) begin
      tag_vld_d[k] = tag_vld_q[k-1];
      tag_id_d[k]  = tag_id_q[k-1];
    end
  end

  // The product is captured only when the matching tag reaches the last stage.
  always_comb begin
    push        = tag_vld_q[MULT_LATENCY-1];
    pop         = res_valid_o && res_ready_i;
    fifo_data_d = fifo_data_q;
    fifo_id_d   = fifo_id_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (push) begin
      fifo_data_d[wr_ptr_q] = mult_p_i;
      fifo_id_d[wr_ptr_q]   = tag_id_q[MULT_LATENCY-1];
      wr_ptr_d              = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= '0;
      mult_vld_q  <= 1'b0;
      mult_a_q    <= '0;
      mult_b_q    <= '0;
      issue_id_q  <= '0;
      tag_vld_q   <= '0;
      tag_id_q    <= '0;
      fifo_data_q <= '0;
      fifo_id_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      ptr_q       <= ptr_d;
      mult_vld_q  <= mult_vld_d;
      mult_a_q    <= mult_a_d;
      mult_b_q    <= mult_b_d;
      issue_id_q  <= issue_id_d;
      tag_vld_q   <= tag_vld_d;
      tag_id_q    <= tag_id_d;
      fifo_data_q <= fifo_data_d;
      fifo_id_q   <= fifo_id_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  assign mult_vld_o  = mult_vld_q;
  assign mult_a_o    = mult_a_q;
  assign mult_b_o    = mult_b_q;
  assign res_valid_o = (count_q != '0);
  assign res_data_o  = fifo_data_q[rd_ptr_q];
  assign res_id_o    = fifo_id_q[rd_ptr_q];
  assign idle_o      = !mult_vld_q && !(|tag_vld_q) && (count_q == '0);

endmodule

// File: doc/mult_rr_scheduler.md
# mult_rr_scheduler

Round-robin scheduler that shares one signed 8-bit multiplier among NUM_REQ requesters in the GAT datapath, e.g. the feature×weight lanes of the attention/aggregation stage. It accepts operand pairs over valid/ready, issues one pair per cycle to an external fixed-latency multiplier, and tracks each in-flight product with a requester ID tag. Products are returned in issue order through a small result FIFO with backpressure. Grants are credit-limited so no product is ever dropped.

## Interface
- NUM_REQ, 4: number of requesters, 2..16
- IN_DATA_WIDTH, 8: signed operand width
- OUT_DATA_WIDTH, 16: signed product width
- MULT_LATENCY, 1: cycles from mult_vld_o to a valid mult_p_i, 1..4
- FIFO_DEPTH, 4: result FIFO entries, power of two, ≥ MULT_LATENCY+3
- ID_W, $clog2(NUM_REQ): requester ID width
- clk  input  1  clock; all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid_i  input  NUM_REQ  per-requester operand valid
- req_ready_o  output  NUM_REQ  per-requester accept; one-hot or zero
- req_a_i  input  NUM_REQ*IN_DATA_WIDTH  operand A, requester i at slice i
- req_b_i  input  NUM_REQ*IN_DATA_WIDTH  operand B, requester i at slice i
- mult_a_o  output  IN_DATA_WIDTH  registered operand A to the multiplier
- mult_b_o  output  IN_DATA_WIDTH  registered operand B to the multiplier
- mult_vld_o  output  1  operands on mult_a_o/mult_b_o are a real issue
- mult_p_i  input  OUT_DATA_WIDTH  multiplier product, MULT_LATENCY cycles after issue
- res_valid_o  output  1  FIFO head valid
- res_ready_i  input  1  consumer accepts the head
- res_data_o  output  OUT_DATA_WIDTH  product at the FIFO head
- res_id_o  output  ID_W  requester ID of the head product
- idle_o  output  1  no operands in flight and FIFO empty

## Operation
- Reset values:
  - req_ready_o=0, mult_vld_o=0, mult_a_o=0, mult_b_o=0.
  - res_valid_o=0, res_data_o=0, res_id_o=0, idle_o=1.
  - Round-robin pointer=0, tag pipeline cleared, FIFO empty.
- Credit check: grant is allowed only when fifo_count + inflight < FIFO_DEPTH.
  - inflight = issue register valid + valid tag stages.
  - A pop in the same cycle does not add credit.
- Arbitration:
  - Among asserted req_valid_i, pick the first index at or after the pointer, wrapping modulo NUM_REQ.
  - req_ready_o[g] is asserted combinationally from req_valid_i and the credit check.
  - A transfer occurs when req_valid_i[g] && req_ready_o[g].
  - On transfer, the pointer becomes (g+1) mod NUM_REQ. Otherwise the pointer holds.
- Requesters hold valid and data stable until accepted; the block never retracts ready for an asserted valid within a cycle.
- Issue: the accepted operands and ID g are registered into mult_a_o, mult_b_o, mult_vld_o and the ID tag.
- Tag pipeline: MULT_LATENCY stages of {valid, id}, advanced every cycle with no stall.
- Capture: when the last tag stage is valid, {mult_p_i, id} is written to the FIFO. Otherwise mult_p_i is ignored.
- Pass-through: mult_p_i is stored unmodified; no width conversion.
- FIFO:
  - Pop on res_valid_o && res_ready_i.
  - Push and pop in the same cycle leaves the count unchanged.
  - The credit scheme guarantees a push never meets a full FIFO.
- Ordering: results leave in global issue order. Per-requester order is preserved.
- idle_o = !mult_vld_o && no valid tag stage && FIFO empty.

## Timing
- Accept in cycle 0 gives mult_vld_o/mult_a_o/mult_b_o in cycle 1.
- mult_p_i is sampled at the end of cycle 1+MULT_LATENCY.
- res_valid_o is earliest in cycle 2+MULT_LATENCY, which is cycle 3 at default.
- Throughput: one accept per cycle sustained while res_ready_i=1.
- res_ready_i low: the FIFO fills and grants stop once credits are exhausted. In-flight products still land in the FIFO.
- res_ready_i high again: credit returns the cycle after the pop. The next grant is one cycle later.
- A single requester holding valid is accepted every cycle when credit allows.
- Reset mid-operation:
  - In-flight tags and FIFO contents are discarded immediately.
  - Any mult_p_i arriving after reset is ignored.
  - The pointer returns to 0.
- No outputs are combinational from mult_p_i. res_* come from FIFO registers.

## Test plan
- Single op: requester 2 sends a=-3, b=7 in cycle 0 with res_ready_i=1. Expect mult_a_o=0xFD and mult_b_o=0x07 in cycle 1, then res_data_o=-21 and res_id_o=2 in cycle 3.
- Fairness: all 4 requesters valid continuously for 8 accepts. Grant order is 0,1,2,3,0,1,2,3 with one accept per cycle.
- Backpressure: hold res_ready_i=0 while all requesters are valid. Exactly 4 accepts occur, then ready stays 0. Release: the 4 results drain in issue order and grants resume.
- Corner products (model a 1-cycle multiplier in the bench):
  - -128×-128 gives 16384.
  - -128×127 gives -16256.
  - 0×-1 gives 0.
- Pointer skip: only requesters 1 and 3 are valid. Grants alternate 1,3,1,3 with no idle cycles.
- Reset mid-flight: assert rst while 2 ops are in flight and 2 results are in the FIFO. Expect res_valid_o=0 and idle_o=1, with no stale result after deassertion. The next accept goes to requester 0.
